// File: rtl/clock_op_scheduler_if.sv
// Button inputs and operation-stream outputs of clock_op_scheduler.
// master drives the raw keys and observes the operation stream; slave is the scheduler side.
interface clock_op_scheduler_if;
    logic       btn_min;
    logic       btn_sec;
    logic       btn_clr;
    logic [1:0] operation;
    logic       op_strobe;
    logic [1:0] held_key;
    logic       repeat_active;

    modport master (
        output btn_min, btn_sec, btn_clr,
        input  operation, op_strobe, held_key, repeat_active
    );

    modport slave (
        input  btn_min, btn_sec, btn_clr,
        output operation, op_strobe, held_key, repeat_active
    );
endinterface

// File: rtl/clock_op_scheduler.sv
// Raw keys -> sync + debounce -> priority FSM -> one-cycle operation strobes, with minute auto-repeat.
// Latency: DEBOUNCE_CYCLES+3 edges from the raw key to op_strobe; no backpressure, events are never queued.
module clock_op_scheduler #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic                  clk,
    input  logic                  rst,
    clock_op_scheduler_if.slave   bus
);

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_MIN  = 2'b10;
    localparam logic [1:0] OP_SEC  = 2'b01;
    localparam logic [1:0] OP_CLR  = 2'b11;

    localparam int DW   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX) + 1;

    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] R_DELAY = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] R_PER   = RW'(REPEAT_PERIOD);

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD, WAIT_REL} state_t;

    // Key index: 0 = min, 1 = sec, 2 = clr.
    logic [2:0]    raw;
    logic [2:0]    sync1_q, sync2_q;
    logic [2:0]    deb_q, deb_d, deb_prev_q;
    logic [DW-1:0] db_cnt_q [3];
    logic [DW-1:0] db_cnt_d [3];
    logic [2:0]    press;
    logic [1:0]    win;

    state_t        state_q, state_d;
    logic [1:0]    code_q, code_d;
    logic          rpt_q, rpt_d;
    logic [RW-1:0] rcnt_q, rcnt_d;

    logic [1:0]    operation_q, operation_d;
    logic          strobe_q, strobe_d;
    logic [1:0]    held_q, held_d;
    logic          ract_q, ract_d;

    assign raw = {bus.btn_clr, bus.btn_sec, bus.btn_min};

    function automatic logic [1:0] rank(input logic [1:0] code);
        case (code)
            OP_CLR:  rank = 2'd3;
            OP_SEC:  rank = 2'd2;
            OP_MIN:  rank = 2'd1;
            default: rank = 2'd0;
        endcase
    endfunction

    // Debounced state flips only after DEBOUNCE_CYCLES consecutive disagreeing cycles.
    always_comb begin
        deb_d = deb_q;
        for (int k = 0; k < 3; k++) begin
            db_cnt_d[k] = '0;
            if (sync2_q[k] != deb_q[k]) begin
                if (db_cnt_q[k] >= DB_LAST) begin
                    deb_d[k] = sync2_q[k];
                end else begin
                    db_cnt_d[k] = db_cnt_q[k] + DW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            for (int k = 0; k < 3; k++) db_cnt_q[k] <= '0;
        end else begin
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            for (int k = 0; k < 3; k++) db_cnt_q[k] <= db_cnt_d[k];
        end
    end

    assign press = deb_q & ~deb_prev_q;

    always_comb begin
        if (press[2])      win = OP_CLR;
        else if (press[1]) win = OP_SEC;
        else if (press[0]) win = OP_MIN;
        else               win = OP_NONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            code_q  <= OP_NONE;
            rpt_q   <= 1'b0;
            rcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            rpt_q   <= rpt_d;
            rcnt_q  <= rcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        rpt_d   = rpt_q;
        rcnt_d  = rcnt_q;
        case (state_q)
            IDLE: begin
                if (win != OP_NONE) begin
                    state_d = ISSUE;
                    code_d  = win;
                    rpt_d   = 1'b0;
                end
            end
            ISSUE: begin
                if (code_q == OP_MIN) begin
                    state_d = HOLD;
                    rcnt_d  = rpt_q ? R_PER : R_DELAY;
                end else begin
                    state_d = WAIT_REL;
                end
            end
            HOLD: begin
                if (press[2] || press[1]) begin
                    state_d = ISSUE;
                    code_d  = win;
                    rpt_d   = 1'b0;
                end else if (!deb_q[0]) begin
                    state_d = IDLE;
                    code_d  = OP_NONE;
                end else if (rcnt_q <= RW'(1)) begin
                    // Counter hits zero this cycle: fire the auto-repeat.
                    state_d = ISSUE;
                    rcnt_d  = '0;
                    rpt_d   = 1'b1;
                end else begin
                    rcnt_d  = rcnt_q - RW'(1);
                end
            end
            WAIT_REL: begin
                if (rank(win) > rank(code_q)) begin
                    state_d = ISSUE;
                    code_d  = win;
                    rpt_d   = 1'b0;
                end else if (deb_q == 3'b000) begin
                    state_d = IDLE;
                    code_d  = OP_NONE;
                end
            end
            default: begin
                state_d = IDLE;
                code_d  = OP_NONE;
            end
        endcase
    end

    // Outputs are decoded from next state so the registered values line up with the state.
    always_comb begin
        operation_d = (state_d == ISSUE) ? code_d : OP_NONE;
        strobe_d    = (state_d == ISSUE);
        held_d      = (state_d == IDLE) ? OP_NONE : code_d;
        ract_d      = (state_d == HOLD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            operation_q <= OP_NONE;
            strobe_q    <= 1'b0;
            held_q      <= OP_NONE;
            ract_q      <= 1'b0;
        end else begin
            operation_q <= operation_d;
            strobe_q    <= strobe_d;
            held_q      <= held_d;
            ract_q      <= ract_d;
        end
    end

    assign bus.operation     = operation_q;
    assign bus.op_strobe     = strobe_q;
    assign bus.held_key      = held_q;
    assign bus.repeat_active = ract_q;

endmodule

// File: tb/tb_clock_op_scheduler.sv
// Scoreboard bench for clock_op_scheduler: expected strobes (cycle, code) are queued as keys are driven
// and matched when the DUT strobes.
module tb_clock_op_scheduler;
    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    clock_op_scheduler_if bus_if ();

    clock_op_scheduler #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         t;
        logic [1:0] op;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Step to 1 time unit after the n-th next rising edge.
    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_op(input int dt, input logic [1:0] op);
        exp_t e;
        e.t  = cyc + dt;
        e.op = op;
        sb.push_back(e);
    endtask

    task automatic drain(input string tag);
        check(tag, sb.size(), 0);
        sb.delete();
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check("strobe_vs_op", int'(bus_if.op_strobe), int'(bus_if.operation != 2'b00));
            if (bus_if.op_strobe) begin
                if (sb.size() == 0) begin
                    check("unexpected_strobe", int'(bus_if.operation), 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("op_code", int'(bus_if.operation), int'(mon_e.op));
                    check("op_cycle", cyc, mon_e.t);
                end
            end
        end
    end

    initial begin
        int c;
        bus_if.btn_min = 1'b0;
        bus_if.btn_sec = 1'b0;
        bus_if.btn_clr = 1'b0;

        wait_cyc(3);
        check("rst_operation", int'(bus_if.operation), 0);
        check("rst_strobe", int'(bus_if.op_strobe), 0);
        check("rst_held", int'(bus_if.held_key), 0);
        check("rst_repeat", int'(bus_if.repeat_active), 0);
        rst = 1'b0;
        wait_cyc(5);

        // Short bounce on sec: shorter than the debounce window.
        bus_if.btn_sec = 1'b1;
        wait_cyc(3);
        bus_if.btn_sec = 1'b0;
        wait_cyc(20);
        check("bounce_operation", int'(bus_if.operation), 0);
        drain("bounce_leftover");

        // Sec held 20 cycles: one 01 strobe, held_key tracks debounced release.
        expect_op(D + 3, 2'b01);
        bus_if.btn_sec = 1'b1;
        wait_cyc(15);
        check("sec_held_key", int'(bus_if.held_key), 1);
        wait_cyc(5);
        bus_if.btn_sec = 1'b0;
        wait_cyc(10);
        check("sec_released_key", int'(bus_if.held_key), 0);
        drain("sec_leftover");

        // Min held 38 cycles: first strobe, then REPEAT_DELAY+1, then REPEAT_PERIOD+1 spacing,
        // until the debounced release (38 + D + 2 cycles after the press).
        expect_op(D + 3, 2'b10);
        for (int t = D + 3 + RD + 1; t <= 38 + D + 2; t += RP + 1) expect_op(t, 2'b10);
        bus_if.btn_min = 1'b1;
        wait_cyc(10);
        check("min_repeat_active", int'(bus_if.repeat_active), 1);
        check("min_held_key", int'(bus_if.held_key), 2);
        wait_cyc(28);
        bus_if.btn_min = 1'b0;
        wait_cyc(12);
        check("min_released_key", int'(bus_if.held_key), 0);
        check("min_released_rpt", int'(bus_if.repeat_active), 0);
        drain("min_leftover");

        // Min and clr together: clr wins, min is discarded.
        expect_op(D + 3, 2'b11);
        bus_if.btn_min = 1'b1;
        bus_if.btn_clr = 1'b1;
        wait_cyc(15);
        check("both_held_key", int'(bus_if.held_key), 3);
        wait_cyc(5);
        bus_if.btn_min = 1'b0;
        bus_if.btn_clr = 1'b0;
        wait_cyc(12);
        check("both_released_key", int'(bus_if.held_key), 0);
        drain("both_leftover");

        // Clr preempts HOLD; min stays held after clr release and must not repeat.
        expect_op(D + 3, 2'b10);
        bus_if.btn_min = 1'b1;
        wait_cyc(9);
        expect_op(D + 3, 2'b11);
        bus_if.btn_clr = 1'b1;
        wait_cyc(11);
        bus_if.btn_clr = 1'b0;
        wait_cyc(5);
        check("preempt_held_key", int'(bus_if.held_key), 3);
        check("preempt_repeat", int'(bus_if.repeat_active), 0);
        wait_cyc(15);
        bus_if.btn_min = 1'b0;
        wait_cyc(15);
        check("preempt_idle_key", int'(bus_if.held_key), 0);
        expect_op(D + 3, 2'b10);
        bus_if.btn_min = 1'b1;
        wait_cyc(9);
        bus_if.btn_min = 1'b0;
        wait_cyc(15);
        drain("preempt_leftover");

        // Reset in HOLD the cycle before an auto-repeat is due.
        c = cyc;
        expect_op(D + 3, 2'b10);
        expect_op(D + 3 + RD + 1, 2'b10);
        bus_if.btn_min = 1'b1;
        wait_cyc(D + 3 + RD + 1 + RP);
        check("pre_rst_cycle", cyc - c, D + 3 + RD + 1 + RP);
        check("pre_rst_repeat", int'(bus_if.repeat_active), 1);
        check("pre_rst_queue", sb.size(), 0);
        rst = 1'b1;
        #1;
        check("mid_rst_operation", int'(bus_if.operation), 0);
        check("mid_rst_strobe", int'(bus_if.op_strobe), 0);
        check("mid_rst_held", int'(bus_if.held_key), 0);
        check("mid_rst_repeat", int'(bus_if.repeat_active), 0);
        wait_cyc(2);
        rst = 1'b0;
        expect_op(D + 3, 2'b10);
        wait_cyc(10);
        bus_if.btn_min = 1'b0;
        wait_cyc(15);
        drain("rst_leftover");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
